// File: rtl/sm_board_panel.sv
// Board front-end for schoolMIPS: debounced keys, run/step/halt clock-enable
// generation, debug register cycling and LED bank.

module sm_board_key #(
  parameter int DEBOUNCE_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic press
);
  logic [1:0]            sync;
  logic                  deb, deb_q;
  logic [DEBOUNCE_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= '0;
      deb   <= 1'b0;
      deb_q <= 1'b0;
      cnt   <= '0;
    end else begin
      sync  <= {sync[0], key};
      deb_q <= deb;
      if (sync[1] == deb)
        cnt <= '0;
      else if (&cnt) begin
        deb <= sync[1];
        cnt <= '0;
      end else
        cnt <= cnt + 1'b1;
    end
  end

  assign press = deb & ~deb_q;
endmodule

module sm_board_panel #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int RESET_ADDR = 2,
  parameter int LED_W      = 4,
  parameter int DIV_W      = 4,
  parameter int DEBOUNCE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  keyMode,
  input  logic                  keyStep,
  input  logic                  keySel,
  input  logic [DIV_W-1:0]      clkDevide,
  input  logic [DATA_W-1:0]     regData,
  output logic                  cpuEn,
  output logic [REG_ADDR_W-1:0] regAddr,
  output logic [1:0]            mode,
  output logic [LED_W-1:0]      led
);
  typedef enum logic [1:0] {RUN = 2'd0, STEP = 2'd1, HALT = 2'd2, BAD = 2'd3} mode_t;

  logic [2:0] keys, press;
  logic       mode_ev, step_ev, sel_ev;

  assign keys = {keySel, keyStep, keyMode};

  sm_board_key #(.DEBOUNCE_W(DEBOUNCE_W)) u_key [2:0] (
    .clk   (clk),
    .rst   (rst),
    .key   (keys),
    .press (press)
  );

  assign {sel_ev, step_ev, mode_ev} = press;

  mode_t             mode_q, mode_nxt;
  logic [DIV_W-1:0]  div_q, div_nxt;
  logic              en_q, en_nxt;
  logic [REG_ADDR_W-1:0] addr_q;
  logic [LED_W-1:0]  led_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= RUN;
      div_q  <= '0;
      en_q   <= 1'b0;
    end else begin
      mode_q <= mode_nxt;
      div_q  <= div_nxt;
      en_q   <= en_nxt;
    end
  end

  always_comb begin
    mode_nxt = mode_q;
    div_nxt  = '0;
    en_nxt   = 1'b0;
    case (mode_q)
      RUN:     if (mode_ev) mode_nxt = STEP;
      STEP:    if (mode_ev) mode_nxt = HALT;
      HALT:    if (mode_ev) mode_nxt = RUN;
      default: mode_nxt = RUN;
    endcase
    // A mode change always wins: divider restarts and no pulse this cycle.
    if (mode_nxt == mode_q) begin
      case (mode_q)
        RUN: begin
          if (div_q == clkDevide) en_nxt = 1'b1;
          else                    div_nxt = div_q + 1'b1;
        end
        STEP:    en_nxt = step_ev;
        default: en_nxt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= REG_ADDR_W'(RESET_ADDR);
      led_q  <= '0;
    end else begin
      if (sel_ev) addr_q <= addr_q + 1'b1;
      led_q[0]         <= led_q[0] ^ en_q;
      led_q[LED_W-1:1] <= regData[LED_W-2:0];
    end
  end

  logic unused_data;
  assign unused_data = ^regData;

  assign cpuEn   = en_q;
  assign regAddr = addr_q;
  assign mode    = mode_q;
  assign led     = led_q;
endmodule
